// File: rtl/vram_dma_pkg.sv
// Shared encodings, default sizing and a small address helper for the VRAM DMA block.
package vram_dma_pkg;

   localparam int AW_DEFAULT        = 14;
   localparam int DW_DEFAULT        = 8;
   localparam int VRAM_SIZE_DEFAULT = 16000;

   localparam logic OP_COPY = 1'b0;
   localparam logic OP_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COPY_RUN = 2'd1,
      FILL_RUN = 2'd2,
      FINISH   = 2'd3
   } dma_state_e;

   // Next VRAM address with wrap from size-1 back to 0.
   function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned size);
      return (addr == size - 1) ? 0 : addr + 1;
   endfunction

endpackage

// File: rtl/vram_port_arb.sv
// Registered host-vs-DMA mux for the VRAM write port. Host writes always win;
// the DMA side sees 'stall' in the same cycle and must keep its request pending.
module vram_port_arb
   import vram_dma_pkg::*;
#(
   parameter int AW = AW_DEFAULT,
   parameter int DW = DW_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          host_wr,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_data,
   input  logic          dma_req,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_data,
   output logic          stall,
   output logic          vram_wr,
   output logic [AW-1:0] vram_addr,
   output logic [DW-1:0] vram_data
);

   logic          wr_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;

   // A DMA request is refused in any cycle the host is writing.
   assign stall = host_wr;

   // Register the winning write; address/data hold their last value when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         wr_q <= host_wr | dma_req;
         if (host_wr) begin
            addr_q <= host_addr;
            data_q <= host_data;
         end else if (dma_req) begin
            addr_q <= dma_addr;
            data_q <= dma_data;
         end
      end
   end

   assign vram_wr   = wr_q;
   assign vram_addr = addr_q;
   assign vram_data = data_q;

endmodule

// File: rtl/vram_dma.sv
// DMA sequencer for the VRAM write port: COPY from the 1-cycle-latency image ROM
// or FILL with a constant byte, sharing the port with host writes.
//
// Handshake: 'start' is a one-cycle request that is accepted only while busy=0;
// there is no back-pressure signal, a request seen while busy=1 is dropped.
// Completion is signalled by a one-cycle 'done' pulse coincident with busy falling.
module vram_dma
   import vram_dma_pkg::*;
#(
   parameter int AW        = AW_DEFAULT,
   parameter int DW        = DW_DEFAULT,
   parameter int VRAM_SIZE = VRAM_SIZE_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          op,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW-1:0] length,
   input  logic [DW-1:0] fill_data,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   input  logic          host_wr,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_data,
   output logic          vram_wr,
   output logic [AW-1:0] vram_addr,
   output logic [DW-1:0] vram_data,
   output logic [1:0]    dbg_state
);

   localparam logic [AW-1:0] ONE = AW'(1);

   dma_state_e    state_q;
   logic          busy_q;
   logic          done_q;
   logic [AW-1:0] rom_addr_q;   // issue stage: address presented to the ROM
   logic [AW-1:0] rom_prev_q;   // address the ROM sampled at the last edge
   logic          prev_vld_q;   // rom_prev_q was a real fetch of this operation
   logic [AW-1:0] next_byte_q;  // ROM address of the next byte not yet held or written
   logic [AW-1:0] dst_q;
   logic [AW-1:0] rem_q;        // bytes still to be written to VRAM
   logic [DW-1:0] fill_q;
   logic [DW-1:0] hold_q;
   logic          hold_vld_q;

   logic          stall;
   logic          rd_ok;
   logic          dma_req;
   logic          dma_fire;
   logic [DW-1:0] dma_data;
   logic [AW-1:0] dst_d;

   // rom_data is usable only when it is the byte the write stage is waiting for;
   // a frozen rom_addr makes the ROM return the same byte twice, and the repeat
   // is what refills the pipeline after the hold register drains.
   assign rd_ok = prev_vld_q && (rom_prev_q == next_byte_q);

   // Select the DMA write candidate for this cycle: held byte first, then ROM, or fill byte.
   always_comb begin
      dma_req  = 1'b0;
      dma_data = fill_q;
      case (state_q)
         COPY_RUN: begin
            if (hold_vld_q) begin
               dma_req  = 1'b1;
               dma_data = hold_q;
            end else if (rd_ok) begin
               dma_req  = 1'b1;
               dma_data = rom_data;
            end
         end
         FILL_RUN: begin
            dma_req  = 1'b1;
            dma_data = fill_q;
         end
         default: begin
            dma_req  = 1'b0;
            dma_data = fill_q;
         end
      endcase
   end

   assign dma_fire = dma_req && !stall;
   assign dst_d    = AW'(wrap_inc(32'(dst_q), VRAM_SIZE));

   // Operation FSM with its counters, ROM issue stage and one-entry hold register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rom_addr_q  <= '0;
         rom_prev_q  <= '0;
         prev_vld_q  <= 1'b0;
         next_byte_q <= '0;
         dst_q       <= '0;
         rem_q       <= '0;
         fill_q      <= '0;
         hold_q      <= '0;
         hold_vld_q  <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         rom_prev_q <= rom_addr_q;
         prev_vld_q <= (state_q == COPY_RUN);

         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q      <= 1'b1;
                  rom_addr_q  <= src_addr;
                  next_byte_q <= src_addr;
                  dst_q       <= dst_addr;
                  rem_q       <= length;
                  fill_q      <= fill_data;
                  hold_vld_q  <= 1'b0;
                  if (length == '0)
                     state_q <= FINISH;
                  else if (op == OP_FILL)
                     state_q <= FILL_RUN;
                  else
                     state_q <= COPY_RUN;
               end
            end

            COPY_RUN: begin
               if (stall) begin
                  // Freeze the issue stage; park a fresh byte if there is room.
                  if (!hold_vld_q && rd_ok) begin
                     hold_q      <= rom_data;
                     hold_vld_q  <= 1'b1;
                     next_byte_q <= next_byte_q + ONE;
                  end
               end else begin
                  rom_addr_q <= rom_addr_q + ONE;
                  if (hold_vld_q)
                     hold_vld_q <= 1'b0;
                  else if (rd_ok)
                     next_byte_q <= next_byte_q + ONE;
               end
            end

            FILL_RUN: begin
               // Nothing beyond the shared write bookkeeping below.
            end

            FINISH: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase

         if (dma_fire) begin
            dst_q <= dst_d;
            rem_q <= rem_q - ONE;
            if (rem_q == ONE)
               state_q <= FINISH;
         end
      end
   end

   vram_port_arb #(
      .AW(AW),
      .DW(DW)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .host_wr   (host_wr),
      .host_addr (host_addr),
      .host_data (host_data),
      .dma_req   (dma_req),
      .dma_addr  (dst_q),
      .dma_data  (dma_data),
      .stall     (stall),
      .vram_wr   (vram_wr),
      .vram_addr (vram_addr),
      .vram_data (vram_data)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign rom_addr  = rom_addr_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: table of block operations with hand-computed
// completion cycles, an expected-write queue checked on every VRAM write,
// plus a hand-written mid-operation reset sequence.
module tb_vram_dma;
   import vram_dma_pkg::*;

   localparam int AW = 14;
   localparam int DW = 8;
   localparam int VS = 16000;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          op = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW-1:0] length = '0;
   logic [DW-1:0] fill_data = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data = '0;
   logic          host_wr = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_data = '0;
   logic          vram_wr;
   logic [AW-1:0] vram_addr;
   logic [DW-1:0] vram_data;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   // Image ROM model: registered, ROM[i] = i[7:0].
   always @(posedge clk) rom_data <= rom_addr[DW-1:0];

   vram_dma #(.AW(AW), .DW(DW), .VRAM_SIZE(VS)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .length    (length),
      .fill_data (fill_data),
      .busy      (busy),
      .done      (done),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .host_wr   (host_wr),
      .host_addr (host_addr),
      .host_data (host_data),
      .vram_wr   (vram_wr),
      .vram_addr (vram_addr),
      .vram_data (vram_data),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [AW+DW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input int addr, input int data);
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'(addr);
      d = DW'(data);
      exp_q.push_back({a, d});
   endtask

   // Every VRAM write must match the head of the expected queue.
   always @(negedge clk) begin
      if (vram_wr !== 1'b0) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL spurious_wr: got write addr %0d data %02h, required no write",
                     vram_addr, vram_data);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            if ({vram_addr, vram_data} !== e) begin
               n_fail++;
               $display("FAIL wr_addr_data: got addr %0d data %02h, required addr %0d data %02h",
                        vram_addr, vram_data, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      int id;
      int op;
      int src;
      int dst;
      int len;
      int fill;
      int host_k;     // cycle index after the start edge (-1 = the start cycle)
      int host_n;     // consecutive host write cycles
      int host_idx;   // DMA write position the host writes precede
      int host_addr;
      int host_data;
      int restart_k;  // cycle at which start is re-pulsed while busy (-1 = never)
      int exp_done;   // cycles after the start edge at which done is seen high
   } vec_t;

   vec_t vecs[8];
   vec_t post_reset_vec;

   // ---------------- driver tasks ----------------
   task automatic drive_host(input vec_t v, input int k);
      host_wr   = (v.host_n > 0) && (k >= v.host_k) && (k < v.host_k + v.host_n);
      host_addr = AW'(v.host_addr);
      host_data = DW'(v.host_data);
   endtask

   task automatic run_op(input vec_t v);
      int done_k;
      done_k = -1;
      for (int i = 0; i < v.len; i++) begin
         if (v.host_n > 0 && i == v.host_idx)
            for (int h = 0; h < v.host_n; h++) push_exp(v.host_addr, v.host_data);
         push_exp((v.dst + i) % VS, (v.op != 0) ? v.fill : ((v.src + i) & 255));
      end

      @(negedge clk);
      start     = 1'b1;
      op        = (v.op != 0);
      src_addr  = AW'(v.src);
      dst_addr  = AW'(v.dst);
      length    = AW'(v.len);
      fill_data = DW'(v.fill);
      drive_host(v, -1);

      for (int k = 0; k < v.exp_done + 40; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk($sformatf("v%0d_busy_after_start", v.id), busy, 1);
            chk($sformatf("v%0d_rom_addr_after_start", v.id), rom_addr, v.src & 16'h3fff);
            // Scramble operands: the DUT must be working from its latched copies.
            op        = ~op;
            src_addr  = src_addr + AW'(37);
            dst_addr  = dst_addr + AW'(11);
            length    = AW'(5);
            fill_data = ~fill_data;
         end
         start = (k == v.restart_k);
         if (done === 1'b1) begin
            done_k = k;
            break;
         end
         drive_host(v, k);
      end
      start   = 1'b0;
      host_wr = 1'b0;

      chk($sformatf("v%0d_done_cycle", v.id), done_k, v.exp_done);
      chk($sformatf("v%0d_busy_at_done", v.id), busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_single_pulse", v.id), done, 0);
      chk($sformatf("v%0d_writes_outstanding", v.id), exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Reset lands on the edge that would register the 5th write of a COPY.
   task automatic reset_mid_copy();
      int saw_done;
      saw_done = 0;
      for (int i = 0; i < 4; i++) push_exp(60 + i, (40 + i) & 255);

      @(negedge clk);
      start    = 1'b1;
      op       = OP_COPY;
      src_addr = AW'(40);
      dst_addr = AW'(60);
      length   = AW'(20);
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) saw_done = 1;
         if (k == 5) reset = 1'b1;
      end
      @(negedge clk);
      chk("rst_vram_wr_after_reset", vram_wr, 0);
      chk("rst_busy_after_reset", busy, 0);
      chk("rst_state_after_reset", dbg_state, IDLE);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1;
      end
      chk("rst_no_done", saw_done, 0);
      chk("rst_busy_stays_low", busy, 0);
      chk("rst_writes_outstanding", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      //             id op src dst    len    fill   hk hn hidx haddr hdata  rk  done
      vecs[0] = '{0, 0,   0,     0, 16000, 8'h00, 0, 0, 0,   0,   8'h00, -1, 16002};
      vecs[1] = '{1, 1,   0, 15998,     4, 8'hA5, 0, 0, 0,   0,   8'h00, -1,     5};
      vecs[2] = '{2, 0, 100,   200,     8, 8'h00, 3, 2, 2,   5,   8'h3C, -1,    12};
      vecs[3] = '{3, 0,   7,     9,     0, 8'h00, 0, 0, 0,   0,   8'h00, -1,     1};
      vecs[4] = '{4, 1,   0,    50,    10, 8'h5A, 0, 0, 0,   0,   8'h00,  3,    11};
      vecs[5] = '{5, 1,   0,    10,     3, 8'h33, 0, 1, 0,  77,   8'hEE, -1,     5};
      vecs[6] = '{6, 0, 300, 15996,     8, 8'h00, 8, 1, 7, 123,   8'h42, -1,    11};
      vecs[7] = '{7, 1,   0,    20,     2, 8'h11,-1, 1, 0,1234,   8'h99, -1,     3};
      post_reset_vec = '{8, 1, 0, 100, 2, 8'hC3, 0, 0, 0, 0, 8'h00, -1, 3};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_vram_wr", vram_wr, 0);
      chk("reset_vram_addr", vram_addr, 0);
      chk("reset_vram_data", vram_data, 0);
      chk("reset_rom_addr", rom_addr, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i]);
         repeat (2) @(negedge clk);
      end

      reset_mid_copy();
      run_op(post_reset_vec);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
